// File: rtl/gray_stream_src_pkg.sv
// Shared image package: frame-source state encoding and default frame geometry.
package gray_stream_src_pkg;

   localparam int DEF_IMAGE_WIDTH  = 320;
   localparam int DEF_IMAGE_HEIGHT = 240;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_READ   = 3'd1,
      ST_GAP    = 3'd2,
      ST_HBLANK = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

endpackage

// File: rtl/gray_stream_src.sv
// Raster-order frame reader: paces reads from a frame memory and emits a
// pixel stream with start-of-frame / end-of-line tags for a 3x3 filter.
module gray_stream_src
   import gray_stream_src_pkg::*;
#(
   parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
   parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
   parameter int ADDR_W       = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        gap_cycles,
   input  logic [15:0]       hblank_cycles,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [7:0]        mem_rd_data,
   output logic              gray_valid,
   output logic [7:0]        gray,
   output logic              sof,
   output logic              eol
);

   localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
   localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMAGE_WIDTH - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
   localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
   localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_e            state_q, state_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [7:0]        gap_lat_q, gap_lat_d;
   logic [15:0]       hb_lat_q, hb_lat_d;

   // Read tags travel one stage alongside the memory latency.
   logic rd_vld_q, rd_vld_d;
   logic rd_sof_q, rd_sof_d;
   logic rd_eol_q, rd_eol_d;
   logic rd_last_q, rd_last_d;

   logic       gray_valid_q, gray_valid_d;
   logic [7:0] gray_q, gray_d;
   logic       sof_q, sof_d;
   logic       eol_q, eol_d;
   logic       last_q, last_d;
   logic       done_q, done_d;

   logic col_last, row_last, accept;

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      gap_lat_d    = gap_lat_q;
      hb_lat_d     = hb_lat_q;
      done_d       = 1'b0;
      rd_vld_d     = 1'b0;
      rd_sof_d     = 1'b0;
      rd_eol_d     = 1'b0;
      rd_last_d    = 1'b0;
      gray_valid_d = rd_vld_q;
      gray_d       = rd_vld_q ? mem_rd_data : gray_q;
      sof_d        = rd_vld_q & rd_sof_q;
      eol_d        = rd_vld_q & rd_eol_q;
      last_d       = rd_vld_q & rd_last_q;

      col_last = (col_q == COL_LAST);
      row_last = (row_q == ROW_LAST);

      // A held start re-arms straight out of the done cycle.
      accept = start & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & done_q));

      case (state_q)
         ST_READ: begin
            rd_vld_d  = 1'b1;
            rd_sof_d  = (row_q == '0) && (col_q == '0);
            rd_eol_d  = col_last;
            rd_last_d = col_last && row_last;
            if (col_last) begin
               col_d = '0;
               if (row_last) begin
                  row_d   = '0;
                  addr_d  = '0;
                  state_d = ST_DONE;
               end else begin
                  row_d  = row_q + ROW_ONE;
                  addr_d = addr_q + ADDR_ONE;
                  if (hb_lat_q != 16'd0) begin
                     cnt_d   = hb_lat_q - 16'd1;
                     state_d = ST_HBLANK;
                  end
               end
            end else begin
               col_d  = col_q + COL_ONE;
               addr_d = addr_q + ADDR_ONE;
               if (gap_lat_q != 8'd0) begin
                  cnt_d   = {8'd0, gap_lat_q} - 16'd1;
                  state_d = ST_GAP;
               end
            end
         end
         ST_GAP, ST_HBLANK: begin
            if (cnt_q == 16'd0) begin
               state_d = ST_READ;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_DONE: begin
            if (done_q) begin
               state_d = ST_IDLE;
            end else if (gray_valid_q && last_q) begin
               done_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (accept) begin
         gap_lat_d = gap_cycles;
         hb_lat_d  = hblank_cycles;
         col_d     = '0;
         row_d     = '0;
         addr_d    = '0;
         cnt_d     = 16'd0;
         state_d   = ST_READ;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         col_q        <= '0;
         row_q        <= '0;
         addr_q       <= '0;
         cnt_q        <= 16'd0;
         gap_lat_q    <= 8'd0;
         hb_lat_q     <= 16'd0;
         rd_vld_q     <= 1'b0;
         rd_sof_q     <= 1'b0;
         rd_eol_q     <= 1'b0;
         rd_last_q    <= 1'b0;
         gray_valid_q <= 1'b0;
         gray_q       <= 8'd0;
         sof_q        <= 1'b0;
         eol_q        <= 1'b0;
         last_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
         gap_lat_q    <= gap_lat_d;
         hb_lat_q     <= hb_lat_d;
         rd_vld_q     <= rd_vld_d;
         rd_sof_q     <= rd_sof_d;
         rd_eol_q     <= rd_eol_d;
         rd_last_q    <= rd_last_d;
         gray_valid_q <= gray_valid_d;
         gray_q       <= gray_d;
         sof_q        <= sof_d;
         eol_q        <= eol_d;
         last_q       <= last_d;
         done_q       <= done_d;
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign mem_rd_en   = (state_q == ST_READ);
   assign mem_rd_addr = addr_q;
   assign gray_valid  = gray_valid_q;
   assign gray        = gray_q;
   assign sof         = sof_q;
   assign eol         = eol_q;

endmodule

// File: tb/tb_gray_stream_src.sv
// Scoreboard bench for gray_stream_src on a 4x3 frame: pixel order, tags,
// pacing, done timing, held start, mid-frame changes and mid-frame reset.
module tb_gray_stream_src;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int AW = $clog2(W * H);

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [7:0]    gap_cycles;
   logic [15:0]   hblank_cycles;
   logic          busy, done, mem_rd_en, gray_valid, sof, eol;
   logic [AW-1:0] mem_rd_addr;
   logic [7:0]    mem_rd_data = 8'd0;
   logic [7:0]    gray;

   gray_stream_src #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .gap_cycles    (gap_cycles),
      .hblank_cycles (hblank_cycles),
      .busy          (busy),
      .done          (done),
      .mem_rd_en     (mem_rd_en),
      .mem_rd_addr   (mem_rd_addr),
      .mem_rd_data   (mem_rd_data),
      .gray_valid    (gray_valid),
      .gray          (gray),
      .sof           (sof),
      .eol           (eol)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:W*H-1];
   initial for (int i = 0; i < W * H; i++) mem[i] = 8'(i);
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int gray;
      bit sof;
      bit eol;
      int cyc;
   } exp_t;

   exp_t sb_q[$];
   int   done_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   // Expected stream for a frame whose start is accepted at edge p;
   // returns the expected done cycle.
   function automatic int push_frame(input int p, input int gap, input int hb);
      int   r = p;
      exp_t e;
      for (int k = 0; k < W * H; k++) begin
         e.gray = k;
         e.sof  = (k == 0);
         e.eol  = ((k % W) == W - 1);
         e.cyc  = r + 2;
         sb_q.push_back(e);
         r = r + 1 + (e.eol ? hb : gap);
      end
      done_q.push_back(e.cyc + 1);
      return e.cyc + 1;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      int   d;
      if (gray_valid) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_pixel", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            $display("pixel gray=%0d sof=%0d eol=%0d cyc=%0d", gray, sof, eol, cyc);
            chk("pix_gray", 32'(gray), 32'(e.gray));
            chk("pix_sof", 32'(sof), 32'(e.sof));
            chk("pix_eol", 32'(eol), 32'(e.eol));
            chk("pix_cyc", cyc, e.cyc);
         end
      end
      if (done) begin
         if (done_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            d = done_q.pop_front();
            $display("done cyc=%0d", cyc);
            chk("done_cyc", cyc, d);
         end
      end
   end

   task automatic start_frame(input int gap, input int hb);
      int p, d;
      @(negedge clk);
      start         = 1'b1;
      gap_cycles    = 8'(gap);
      hblank_cycles = 16'(hb);
      p = cyc + 1;
      d = push_frame(p, gap, hb);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 3000 && (sb_q.size() > 0 || done_q.size() > 0); i++)
         @(negedge clk);
      chk("drain_left", 32'(sb_q.size() + done_q.size()), 32'd0);
      repeat (3) @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      int p, d1, d2, n;
      rst           = 1'b0;
      start         = 1'b0;
      gap_cycles    = 8'd0;
      hblank_cycles = 16'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
      chk("rst_addr", 32'(mem_rd_addr), 32'd0);
      chk("rst_valid", 32'(gray_valid), 32'd0);
      chk("rst_gray", 32'(gray), 32'd0);
      chk("rst_sof", 32'(sof), 32'd0);
      chk("rst_eol", 32'(eol), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Back-to-back frame
      start_frame(0, 0);
      drain();

      // Paced frame with mid-frame start pulse and input changes
      start_frame(2, 5);
      repeat (8) @(negedge clk);
      start         = 1'b1;
      gap_cycles    = 8'd0;
      hblank_cycles = 16'd1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      chk("mid_busy", 32'(busy), 32'd1);
      drain();

      // start held high across two frames
      @(negedge clk);
      start         = 1'b1;
      gap_cycles    = 8'd0;
      hblank_cycles = 16'd0;
      p  = cyc + 1;
      d1 = push_frame(p, 0, 0);
      d2 = push_frame(d1 + 1, 0, 0);
      for (int i = 0; i < 200 && cyc < d1 + 1; i++) @(negedge clk);
      chk("held_rd_en", 32'(mem_rd_en), 32'd1);
      chk("held_rd_addr", 32'(mem_rd_addr), 32'd0);
      start = 1'b0;
      drain();
      chk("held_done2", 32'(d2 > d1), 32'd1);

      // Reset after the 5th read
      @(negedge clk);
      start         = 1'b1;
      gap_cycles    = 8'd0;
      hblank_cycles = 16'd0;
      p  = cyc + 1;
      d1 = push_frame(p, 0, 0);
      n  = 0;
      for (int i = 0; i < 200 && n < 5; i++) begin
         @(negedge clk);
         if (cyc == p) start = 1'b0;
         if (mem_rd_en) n++;
      end
      chk("pre_rst_reads", 32'(n), 32'd5);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      @(negedge clk);
      sb_q.delete();
      done_q.delete();
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_valid", 32'(gray_valid), 32'd0);
      chk("post_rst_rd_en", 32'(mem_rd_en), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("quiet_rd_en", 32'(mem_rd_en), 32'd0);
         chk("quiet_valid", 32'(gray_valid), 32'd0);
      end

      // Recovery frame after reset
      start_frame(1, 2);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gray_stream_src.md
GRAY_STREAM_SRC -- requirements
Module: gray_stream_src

Interface
REQ-001 The block SHALL have parameter IMAGE_WIDTH, default 320, meaning pixels per row.
REQ-002 The block SHALL have parameter IMAGE_HEIGHT, default 240, meaning rows per frame.
REQ-003 The block SHALL have parameter ADDR_W, default $clog2(IMAGE_WIDTH*IMAGE_HEIGHT), meaning the frame-memory address width.
REQ-004 The block SHALL have one clock; reset is synchronous and active-low.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous active-low reset; 0 = reset.
REQ-007 The block SHALL have port start, input, 1 bit: frame request, sampled only in IDLE.
REQ-008 The block SHALL have port gap_cycles, input, 8 bits: idle cycles between pixel reads within a row.
REQ-009 The block SHALL have port hblank_cycles, input, 16 bits: idle cycles between rows.
REQ-010 The block SHALL have port busy, output, 1 bit: frame in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle end-of-frame pulse.
REQ-012 The block SHALL have port mem_rd_en, output, 1 bit: frame-memory read strobe.
REQ-013 The block SHALL have port mem_rd_addr, output, ADDR_W bits: raster address = row*IMAGE_WIDTH + col.
REQ-014 The block SHALL have port mem_rd_data, input, 8 bits: read data, valid exactly 1 cycle after mem_rd_en.
REQ-015 The block SHALL have port gray_valid, output, 1 bit: pixel strobe for the downstream 3x3 filter.
REQ-016 The block SHALL have port gray, output, 8 bits: pixel value.
REQ-017 The block SHALL have port sof, output, 1 bit: high with the pixel at (0,0).
REQ-018 The block SHALL have port eol, output, 1 bit: high with the last pixel of each row.

Function
REQ-019 The block SHALL implement the states IDLE, READ, GAP, HBLANK and DONE.
REQ-020 In IDLE with start=1, the block SHALL latch gap_cycles and hblank_cycles, clear the row/col counters, and enter READ on the next cycle.
REQ-021 In READ, the block SHALL assert mem_rd_en for exactly one cycle with the current address, then advance col, or wrap col to 0 and increment row at IMAGE_WIDTH-1.
REQ-022 After READ of a non-last-in-row pixel, the block SHALL go to GAP if the latched gap is greater than 0, else stay in READ, giving back-to-back reads.
REQ-023 After READ of the last pixel in a non-last row, the block SHALL go to HBLANK if the latched hblank is greater than 0, else to READ; the gap SHALL NOT be added at row end.
REQ-024 GAP and HBLANK SHALL each last exactly the latched cycle count, counted by a down-counter, then return to READ.
REQ-025 After READ of pixel (IMAGE_HEIGHT-1, IMAGE_WIDTH-1), the block SHALL enter DONE.
REQ-026 gray, gray_valid, sof and eol SHALL be registered from mem_rd_data and the delayed read tags: gray_valid rises 2 cycles after the corresponding mem_rd_en.
REQ-027 DONE SHALL wait until the final gray_valid has been emitted, pulse done for 1 cycle in the following cycle, then return to IDLE.
REQ-028 busy SHALL be high from the cycle after start is accepted through the done cycle inclusive.
REQ-029 start while busy SHALL be ignored; start=1 held continuously SHALL begin a new frame on the cycle after done.
REQ-030 Exactly IMAGE_WIDTH*IMAGE_HEIGHT gray_valid pulses SHALL occur per frame, in raster order, each pixel exactly once.
REQ-031 gap_cycles and hblank_cycles changes mid-frame SHALL have no effect until the next start.
REQ-032 The address SHALL be computed incrementally (+1 per read), not with a multiplier; the address SHALL never exceed IMAGE_WIDTH*IMAGE_HEIGHT-1.

Reset
REQ-033 With rst=0 at a clock edge, the block SHALL enter IDLE and clear all counters and latched values.
REQ-034 With rst=0 at a clock edge, busy, done, mem_rd_en, gray_valid, sof and eol SHALL be 0, and mem_rd_addr and gray SHALL be 0.
REQ-035 Reset mid-frame SHALL abort the frame with no further reads or gray_valid, and any in-flight read data SHALL be discarded.

Structure
REQ-036 A shared image package SHALL hold the state encoding and the default IMAGE_WIDTH/IMAGE_HEIGHT constants.
REQ-037 The block SHALL be single-module; no sub-module is required.

Verification
REQ-038 W=4, H=3, gap=0, hblank=0, memory[i]=i, start at cycle 0: the bench SHALL see 12 consecutive gray_valid cycles with gray 0..11 and sof with gray=0.
REQ-039 Same configuration: the bench SHALL see eol with gray 3, 7 and 11, and done exactly 1 cycle after the gray=11 pulse.
REQ-040 W=4, H=3, gap=2, hblank=5: the bench SHALL see gray_valid pulses 3 cycles apart within a row and 6 cycles apart across a row boundary, with 12 pulses total.
REQ-041 start pulsed again mid-frame, and gap_cycles changed mid-frame: the bench SHALL see no restart and unchanged spacing.
REQ-042 start held high: the bench SHALL see the second frame's first mem_rd_en in the cycle after done, with sof again at gray=0.
REQ-043 rst=0 asserted after the 5th read: on the next cycle the bench SHALL see busy=0, gray_valid=0 and mem_rd_en=0, and no further outputs until a new start.
